// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, character width and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clocks per oversample tick; truncating division.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset value.
module rx_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN for 8E1 with a
// parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned TcntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DATA_BITS);

  localparam logic [DivW-1:0]  DivMax  = DivW'(Div - 1);
  localparam logic [TcntW-1:0] HalfMax = TcntW'(OVERSAMPLE / 2 - 1);
  localparam logic [TcntW-1:0] BitMax  = TcntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [DivW-1:0]      div_q;
  logic [TcntW-1:0]     tcnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 armed_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 tick;
  logic                 at_half;
  logic                 at_centre;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 perr_q;
`endif

  rx_sync #(
    .ResetVal(1'b1)
  ) u_rx_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  assign tick      = (div_q == DivMax);
  assign at_half   = tick && (tcnt_q == HalfMax);
  assign at_centre = tick && (tcnt_q == BitMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      // Divider held in IDLE so the sampling phase is referenced to the start edge.
      if (state_q == StIdle || tick) div_q <= '0;
      else                           div_q <= div_q + 1'b1;
      if (tick) tcnt_q <= tcnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          tcnt_q <= '0;
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (at_half) begin
            tcnt_q <= '0;
            idx_q  <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (at_centre) begin
            tcnt_q  <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IdxMax) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (at_centre) begin
            tcnt_q  <= '0;
            par_q   <= rx_s;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          // Leave at mid-stop so a back-to-back start edge is caught.
          if (at_centre) begin
            tcnt_q  <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
              armed_q <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            perr_q <= ^{shift_q, par_q};
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural line driver pushes expected characters, and a
// monitor pops and checks them on each strobe.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 6_400_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Os      = 16;
  localparam int unsigned Div     = ClkFreq / (Baud * Os);
  localparam int unsigned BitClk  = Div * Os;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned HalfBits = 21;
`else
  localparam int unsigned HalfBits = 19;
`endif
  // Start edge to strobe: half-bits to the stop centre plus the synchronizer and output flop.
  localparam int unsigned LatNom = HalfBits * BitClk / 2 + 3;

  typedef struct {
    bit          ferr;
    bit          perr;
    logic [7:0]  data;
    int unsigned t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  exp_t        sb[$];
  exp_t        e_m;
  int unsigned lat_m;
  logic [7:0]  last_good = 8'h00;
  bit          mon_en = 1'b0;

  uart_rx #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (Baud),
    .OVERSAMPLE(Os)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && (data_valid || frame_err)) begin
      chk("strobe_exclusive", data_valid && frame_err, 0);
      chk("strobe_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_m   = sb.pop_front();
        lat_m = cyc - e_m.t0;
        chk("frame_err", frame_err, e_m.ferr);
        chk("data_valid", data_valid, !e_m.ferr);
        chk("data_out", data_out, e_m.ferr ? last_good : e_m.data);
        if (!e_m.ferr) last_good = e_m.data;
        chk("latency", (lat_m + Div >= LatNom && lat_m <= LatNom + Div) ? LatNom : lat_m, LatNom);
`ifdef UART_RX_PARITY_EN
        chk("parity_err", parity_err, e_m.perr);
`endif
      end
    end
  end

  // Called at 1 time unit past a rising edge; returns at the same phase.
  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    exp_t e;
    e.ferr = !stop_ok;
    e.perr = !par_ok;
    e.data = b;
    e.t0   = cyc;
    sb.push_back(e);
    hold(1'b0, BitClk);
    for (int i = 0; i < 8; i++) hold(b[i], BitClk);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ !par_ok, BitClk);
`endif
    hold(stop_ok, BitClk);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20 * BitClk) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    logic [7:0]  b;
    int unsigned n;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    hold(1'b1, 16);

    send(8'hA5, 1, 1);
    hold(1'b1, BitClk);
    drain();

    // Back-to-back with no idle gap.
    send(8'h00, 1, 1);
    send(8'hFF, 1, 1);
    hold(1'b1, BitClk);
    drain();

    // Glitch: 5 ticks low, then high before the half-bit start check.
    hold(1'b0, 5 * Div);
    chk("glitch_busy_set", busy, 1);
    rx = 1'b1;
    n  = 0;
    while (busy && n < (Os / 2) * Div + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("glitch_busy_clear", busy, 0);
    hold(1'b1, 2 * BitClk);
    chk("glitch_no_strobe", sb.size(), 0);

    // Bad stop bit, then a break held for two frame times.
    send(8'h3C, 0, 1);
    hold(1'b0, 20 * BitClk);
    chk("break_idle", busy, 0);
    hold(1'b1, 2 * BitClk);
    send(8'h55, 1, 1);
    hold(1'b1, BitClk);
    drain();

    // Reset during data bit 4 aborts the frame with no strobe.
    b = 8'h96;
    hold(1'b0, BitClk);
    for (int i = 0; i < 4; i++) hold(b[i], BitClk);
    hold(b[4], BitClk / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    chk("abort_busy", busy, 0);
    hold(1'b1, BitClk);
    last_good = 8'h00;
    send(8'h81, 1, 1);
    hold(1'b1, BitClk);
`ifdef UART_RX_PARITY_EN
    send(8'h81, 1, 0);
    hold(1'b1, BitClk);
`endif
    drain();

    // Random bytes with random idle gaps, including none.
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
`ifdef UART_RX_PARITY_EN
      send(b, 1, bit'($urandom_range(0, 1)));
`else
      send(b, 1, 1);
`endif
      hold(1'b1, $urandom_range(0, 3) * (BitClk / 4));
    end
    hold(1'b1, BitClk);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
